alu_unit: RTL and testbench

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/alu_unit.sv | 96 +++++++++
 tb/tb_alu_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcode encoding, the registered flag
// bundle and the helper that classifies an opcode into its flag group.
package alu_pkg;

    // Operation select encoding driven on alu_fun.
    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_DIV  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_NAND = 4'b0110,
        OP_NOR  = 4'b0111,
        OP_XOR  = 4'b1000,
        OP_XNOR = 4'b1001,
        OP_EQ   = 4'b1010,
        OP_GT   = 4'b1011,
        OP_LT   = 4'b1100,
        OP_SHR  = 4'b1101,
        OP_SHL  = 4'b1110,
        OP_NOP  = 4'b1111
    } alu_op_e;

    // Values produced by the compare operations when their condition holds.
    // Each compare has its own code so the consumer can tell them apart.
    localparam logic [1:0] CMP_EQ_TRUE = 2'd1;
    localparam logic [1:0] CMP_GT_TRUE = 2'd2;
    localparam logic [1:0] CMP_LT_TRUE = 2'd3;

    // One bit per operation class; at most one is ever set.
    typedef struct packed {
        logic arith;
        logic logical;
        logic cmp;
        logic shift;
    } alu_flags_t;

    // Opcodes are grouped in contiguous ranges, so the class falls out of
    // simple range checks. NOP belongs to no class and leaves all flags low.
    function automatic alu_flags_t decode_flags(input logic [3:0] op);
        alu_flags_t f;
        f = '0;
        if (op <= OP_DIV) begin
            f.arith = 1'b1;
        end else if (op <= OP_XNOR) begin
            f.logical = 1'b1;
        end else if (op <= OP_LT) begin
            f.cmp = 1'b1;
        end else if (op <= OP_SHL) begin
            f.shift = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/alu_unit.sv
// Registered ALU: a single combinational decode of alu_fun feeding one
// output register bank, giving a fixed one-cycle latency.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         alu_fun,
    output logic [2*WIDTH-1:0] alu_out,
    output logic               arith_flag,
    output logic               logic_flag,
    output logic               cmp_flag,
    output logic               shift_flag
);

    localparam int OUT_W = 2 * WIDTH;

    // Operands widened once so arithmetic naturally produces the carry,
    // the full product and a subtraction wrapped at the output width.
    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;
    logic [OUT_W-1:0] result_next;
    alu_flags_t       flags_next;

    assign a_ext = {{WIDTH{1'b0}}, a};
    assign b_ext = {{WIDTH{1'b0}}, b};

    // Result selection; logic and shift results are formed at WIDTH bits
    // and zero-extended, so the shift-left drops a's top bit entirely.
    always_comb begin
        result_next = '0;
        case (alu_op_e'(alu_fun))
            OP_ADD:  result_next = a_ext + b_ext;
            OP_SUB:  result_next = a_ext - b_ext;
            OP_MUL:  result_next = a_ext * b_ext;
            OP_DIV:  begin
                if (b != '0) begin
                    result_next = a_ext / b_ext;
                end
            end
            OP_AND:  result_next = {{WIDTH{1'b0}}, a & b};
            OP_OR:   result_next = {{WIDTH{1'b0}}, a | b};
            OP_NAND: result_next = {{WIDTH{1'b0}}, ~(a & b)};
            OP_NOR:  result_next = {{WIDTH{1'b0}}, ~(a | b)};
            OP_XOR:  result_next = {{WIDTH{1'b0}}, a ^ b};
            OP_XNOR: result_next = {{WIDTH{1'b0}}, ~(a ^ b)};
            OP_EQ:   begin
                if (a == b) begin
                    result_next = {{(OUT_W-2){1'b0}}, CMP_EQ_TRUE};
                end
            end
            OP_GT:   begin
                if (a > b) begin
                    result_next = {{(OUT_W-2){1'b0}}, CMP_GT_TRUE};
                end
            end
            OP_LT:   begin
                if (a < b) begin
                    result_next = {{(OUT_W-2){1'b0}}, CMP_LT_TRUE};
                end
            end
            OP_SHR:  result_next = {{WIDTH{1'b0}}, a >> 1};
            OP_SHL:  result_next = {{WIDTH{1'b0}}, a << 1};
            OP_NOP:  result_next = '0;
            default: result_next = '0;
        endcase
    end

    // Flag class of the operation about to be captured.
    always_comb begin
        flags_next = decode_flags(alu_fun);
    end

    // Output register bank; reset clears everything at once and any result
    // that would have been captured is simply lost.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_out    <= '0;
            arith_flag <= 1'b0;
            logic_flag <= 1'b0;
            cmp_flag   <= 1'b0;
            shift_flag <= 1'b0;
        end else begin
            alu_out    <= result_next;
            arith_flag <= flags_next.arith;
            logic_flag <= flags_next.logical;
            cmp_flag   <= flags_next.cmp;
            shift_flag <= flags_next.shift;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Testbench for alu_unit: directed and random operations are pushed into a
// scoreboard queue by the driver and popped by a monitor after each edge.
module tb_alu_unit;

    localparam int WIDTH = 16;

    logic               CLK;
    logic               RST;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [3:0]         alu_fun;
    logic [2*WIDTH-1:0] alu_out;
    logic               arith_flag;
    logic               logic_flag;
    logic               cmp_flag;
    logic               shift_flag;

    typedef struct packed {
        logic [31:0] out;
        logic [3:0]  flags;
    } exp_t;

    exp_t expq[$];
    int   idq[$];
    exp_t last_exp;
    bit   have_prev;
    int   check_count;
    int   error_count;
    int   stim_id;

    alu_unit #(.WIDTH(WIDTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .a          (a),
        .b          (b),
        .alu_fun    (alu_fun),
        .alu_out    (alu_out),
        .arith_flag (arith_flag),
        .logic_flag (logic_flag),
        .cmp_flag   (cmp_flag),
        .shift_flag (shift_flag)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference behaviour written straight from the operation table using
    // plain integer arithmetic on 16-bit operands and a 32-bit result.
    function automatic exp_t model(input int unsigned av, input int unsigned bv,
                                   input int unsigned op);
        exp_t        e;
        longint      r;
        longint      x;
        longint      y;
        x = longint'(av);
        y = longint'(bv);
        case (op)
            0:  r = x + y;
            1:  r = (64'd4294967296 + x - y) % 64'd4294967296;
            2:  r = x * y;
            3:  r = (y == 0) ? 0 : x / y;
            4:  r = x & y;
            5:  r = x | y;
            6:  r = 65535 - (x & y);
            7:  r = 65535 - (x | y);
            8:  r = x ^ y;
            9:  r = 65535 - (x ^ y);
            10: r = (x == y) ? 1 : 0;
            11: r = (x > y) ? 2 : 0;
            12: r = (x < y) ? 3 : 0;
            13: r = x / 2;
            14: r = (x * 2) % 65536;
            default: r = 0;
        endcase
        e.out      = r[31:0];
        e.flags[3] = (op <= 3);
        e.flags[2] = (op >= 4 && op <= 9);
        e.flags[1] = (op >= 10 && op <= 12);
        e.flags[0] = (op == 13 || op == 14);
        return e;
    endfunction

    // Compare the DUT outputs with one expected entry and also confirm the
    // flags are never more than one-hot.
    task automatic checkOutput(input exp_t e, input int id, input string name);
        logic [3:0] got_flags;
        got_flags = {arith_flag, logic_flag, cmp_flag, shift_flag};
        check_count++;
        if (alu_out !== e.out || got_flags !== e.flags) begin
            error_count++;
            $display("[TB] FAIL %s #%0d: got out=%h flags=%b, expected out=%h flags=%b",
                     name, id, alu_out, got_flags, e.out, e.flags);
        end
        check_count++;
        if ($countones(got_flags) > 1) begin
            error_count++;
            $display("[TB] FAIL onehot %s #%0d: got flags=%b, expected at most one set",
                     name, id, got_flags);
        end
    endtask

    // Drive one operation on the falling edge and queue its expected result.
    // Once the new inputs settle, the outputs must still show the previous
    // operation because nothing updates between rising edges.
    task automatic applyStimulus(input int unsigned av, input int unsigned bv,
                                 input int unsigned op);
        exp_t e;
        @(negedge CLK);
        a       = av[WIDTH-1:0];
        b       = bv[WIDTH-1:0];
        alu_fun = op[3:0];
        e = model(av & 32'hFFFF, bv & 32'hFFFF, op & 32'hF);
        expq.push_back(e);
        idq.push_back(stim_id);
        stim_id++;
        if (have_prev) begin
            #1;
            checkOutput(last_exp, stim_id - 1, "hold_between_edges");
        end
        last_exp  = e;
        have_prev = 1'b1;
    endtask

    // Monitor: one result appears per rising edge while out of reset.
    initial begin : monitor
        exp_t e;
        int   id;
        forever begin
            @(posedge CLK);
            #1;
            if (RST === 1'b1 && expq.size() > 0) begin
                e  = expq.pop_front();
                id = idq.pop_front();
                checkOutput(e, id, "result");
            end
        end
    end

    // Stimulus sequence.
    initial begin : driver
        exp_t zero;
        int unsigned ra;
        int unsigned rb;
        zero        = '0;
        check_count = 0;
        error_count = 0;
        stim_id     = 0;
        have_prev   = 1'b0;

        // Asynchronous reset before any clock edge has occurred.
        RST     = 1'b1;
        a       = 16'd5;
        b       = 16'd3;
        alu_fun = 4'b0000;
        #2;
        RST = 1'b0;
        #1;
        checkOutput(zero, 0, "async_reset");
        repeat (2) @(posedge CLK);
        #1;
        checkOutput(zero, 0, "reset_held");
        @(negedge CLK);
        RST = 1'b1;

        // Arithmetic.
        applyStimulus(5, 3, 0);
        applyStimulus(5, 3, 1);
        applyStimulus(10, 2, 2);
        applyStimulus(500, 10, 3);
        applyStimulus(3, 5, 1);
        applyStimulus(500, 0, 3);
        applyStimulus(16'hFFFF, 16'hFFFF, 0);
        applyStimulus(16'hFFFF, 16'hFFFF, 2);
        applyStimulus(0, 16'hFFFF, 1);
        // Logic on 4'b1010 / 4'b1111.
        for (int op = 4; op <= 9; op++) begin
            applyStimulus(10, 15, op);
        end
        // Compare.
        applyStimulus(10, 10, 10);
        applyStimulus(50, 10, 11);
        applyStimulus(9, 10, 12);
        applyStimulus(9, 10, 11);
        applyStimulus(16'hFFFF, 0, 12);
        // Shift and no-op.
        applyStimulus(26, 0, 13);
        applyStimulus(26, 0, 14);
        applyStimulus(16'h8001, 0, 14);
        applyStimulus(50, 100, 15);

        // Reset pulled mid-cycle discards the operation just issued.
        applyStimulus(7, 9, 0);
        #2;
        RST = 1'b0;
        #1;
        checkOutput(zero, stim_id, "mid_reset_clear");
        expq.delete();
        idq.delete();
        have_prev = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput(zero, stim_id, "mid_reset_hold");
        @(negedge CLK);
        RST = 1'b1;

        // Randomized operations, with extra weight on zero and equal operands.
        for (int i = 0; i < 300; i++) begin
            ra = $urandom_range(0, 65535);
            rb = $urandom_range(0, 65535);
            case ($urandom_range(0, 7))
                0: rb = 0;
                1: rb = ra;
                2: rb = $urandom_range(1, 20);
                default: ;
            endcase
            applyStimulus(ra, rb, $urandom_range(0, 15));
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && expq.size() > 0; i++) begin
            @(posedge CLK);
        end
        #2;
        check_count++;
        if (expq.size() != 0) begin
            error_count++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
